// File: rtl/ct_idu_is_aiq_lch_sel.sv
// ct_idu_is_aiq_lch_sel: oldest-ready AIQ entry select feeding an IS->RF launch pipe with freeze tracking
module ct_idu_is_aiq_lch_sel #(
  parameter int ENTRY = 8,
  parameter int SRC   = 3
) (
  input  logic                     cpuclk_i,
  input  logic                     cpurst_b_i,
  input  logic                     rtu_idu_flush_is_i,
  input  logic [ENTRY-1:0]         entry_vld_i,
  input  logic [ENTRY*SRC-1:0]     entry_lch_rdy_i,
  input  logic [ENTRY*ENTRY-1:0]   entry_age_vec_i,
  input  logic                     rf_stall_i,
  input  logic                     rf_lch_fail_i,
  output logic [ENTRY-1:0]         is_sel_entry_o,
  output logic                     rf_vld_o,
  output logic [ENTRY-1:0]         rf_entry_o,
  output logic [ENTRY-1:0]         rf_pop_entry_o,
  output logic [ENTRY-1:0]         entry_frz_o
);
  logic [ENTRY-1:0] rdy, sel, done_mask;
  logic [ENTRY-1:0] rf_entry_q, rf_entry_d, frz_q, frz_d;
  logic             rf_vld_q, rf_vld_d, rf_hold, rf_done;

  for (genvar i = 0; i < ENTRY; i++) begin : g_sel
    assign rdy[i] = entry_vld_i[i] & ~frz_q[i] & (&entry_lch_rdy_i[i*SRC+:SRC]);
    assign sel[i] = rdy[i] & ~|(rdy & entry_age_vec_i[i*ENTRY+:ENTRY]);
  end

  assign rf_hold        = rf_vld_q & rf_stall_i;
  assign rf_done        = rf_vld_q & ~rf_stall_i;
  assign is_sel_entry_o = sel & {ENTRY{~rf_hold & ~rtu_idu_flush_is_i}};
  assign rf_pop_entry_o = rf_entry_q & {ENTRY{rf_done & ~rf_lch_fail_i}};
  assign done_mask      = rf_entry_q & {ENTRY{rf_done}};
  assign rf_vld_o       = rf_vld_q;
  assign rf_entry_o     = rf_entry_q;
  assign entry_frz_o    = frz_q;

  // Next state: flush kills the pipe and all freezes; a stall holds the pipe; a launch outcome (ok or fail) unfreezes its entry
  always_comb begin
    rf_vld_d   = rtu_idu_flush_is_i ? 1'b0 : rf_hold ? rf_vld_q : |is_sel_entry_o;
    rf_entry_d = rtu_idu_flush_is_i ? '0 : rf_hold ? rf_entry_q : is_sel_entry_o;
    frz_d      = rtu_idu_flush_is_i ? '0 : is_sel_entry_o | (frz_q & ~done_mask & entry_vld_i);
  end

  // State registers with asynchronous reset
  always_ff @(posedge cpuclk_i or negedge cpurst_b_i) begin
    if (!cpurst_b_i) begin
      rf_vld_q   <= 1'b0;
      rf_entry_q <= '0;
      frz_q      <= '0;
    end else begin
      rf_vld_q   <= rf_vld_d;
      rf_entry_q <= rf_entry_d;
      frz_q      <= frz_d;
    end
  end

  // A consistent age order can never leave two ready entries both looking oldest
  assert property (@(posedge cpuclk_i) disable iff (!cpurst_b_i) $onehot0(sel))
    else $error("age matrix inconsistent: multiple entries selected");
endmodule

// File: tb/tb_ct_idu_is_aiq_lch_sel.sv
// tb_ct_idu_is_aiq_lch_sel: directed scoreboard bench for the AIQ launch select
module tb_ct_idu_is_aiq_lch_sel;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  vld = '0;
  logic [23:0] lrdy = '0;
  logic [63:0] agev = '0;
  logic        stall = 1'b0;
  logic        fail = 1'b0;
  logic [7:0]  sel, rfe, pop, frz;
  logic        rfv;

  typedef struct {
    int         id;
    logic [7:0] sel;
    logic       rfv;
    logic [7:0] rfe;
    logic [7:0] pop;
    logic [7:0] frz;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   sid = 0;

  ct_idu_is_aiq_lch_sel #(.ENTRY(8), .SRC(3)) dut (
    .cpuclk_i(clk),
    .cpurst_b_i(rst_b),
    .rtu_idu_flush_is_i(flush),
    .entry_vld_i(vld),
    .entry_lch_rdy_i(lrdy),
    .entry_age_vec_i(agev),
    .rf_stall_i(stall),
    .rf_lch_fail_i(fail),
    .is_sel_entry_o(sel),
    .rf_vld_o(rfv),
    .rf_entry_o(rfe),
    .rf_pop_entry_o(pop),
    .entry_frz_o(frz)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] full(input logic [7:0] m);
    logic [23:0] r = '0;
    for (int i = 0; i < 8; i++) r[i*3+:3] = m[i] ? 3'b111 : 3'b000;
    return r;
  endfunction

  // rev=0: lower index is older; rev=1: higher index is older
  function automatic logic [63:0] age(input bit rev);
    logic [63:0] a = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        a[i*8+j] = rev ? (j > i) : (j < i);
    return a;
  endfunction

  task automatic chk8(input string nm, input int id, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL step%0d %s: got %h expected %h", id, nm, act, req);
    end
  endtask

  task automatic step(input logic r, input logic fl, input logic [7:0] v, input logic [23:0] lr,
                      input bit rev, input logic st, input logic fa,
                      input logic [7:0] e_sel, input logic e_rfv, input logic [7:0] e_rfe,
                      input logic [7:0] e_pop, input logic [7:0] e_frz);
    exp_t e;
    @(posedge clk);
    #1;
    rst_b = r; flush = fl; vld = v; lrdy = lr; agev = age(rev); stall = st; fail = fa;
    e.id = sid; e.sel = e_sel; e.rfv = e_rfv; e.rfe = e_rfe; e.pop = e_pop; e.frz = e_frz;
    q.push_back(e);
    sid++;
  endtask

  // Monitor: compare DUT outputs against the scoreboard away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk8("is_sel_entry", e.id, sel, e.sel);
        chk8("rf_vld", e.id, {7'd0, rfv}, {7'd0, e.rfv});
        chk8("rf_entry", e.id, rfe, e.rfe);
        chk8("rf_pop_entry", e.id, pop, e.pop);
        chk8("entry_frz", e.id, frz, e.frz);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    //   rst fl  vld    lch_rdy          rev st fa   sel    rfv  rfe    pop    frz
    step(1, 0, 8'h00, 24'h0,            0, 0, 0,  8'h00, 0, 8'h00, 8'h00, 8'h00);
    // E2,E5 ready, E5 older
    step(1, 0, 8'h24, full(8'h24),      1, 0, 0,  8'h20, 0, 8'h00, 8'h00, 8'h00);
    step(1, 0, 8'h24, full(8'h24),      1, 0, 0,  8'h04, 1, 8'h20, 8'h20, 8'h20);
    step(1, 0, 8'h00, 24'h0,            0, 0, 0,  8'h00, 1, 8'h04, 8'h04, 8'h04);
    // E3 one source not ready
    step(1, 0, 8'h08, 24'b011 << 9,     0, 0, 0,  8'h00, 0, 8'h00, 8'h00, 8'h00);
    step(1, 0, 8'h08, 24'b011 << 9,     0, 0, 0,  8'h00, 0, 8'h00, 8'h00, 8'h00);
    // E1 into pipe, stalled 3 cycles with E4 ready
    step(1, 0, 8'h02, full(8'h02),      0, 0, 0,  8'h02, 0, 8'h00, 8'h00, 8'h00);
    step(1, 0, 8'h12, full(8'h12),      0, 1, 0,  8'h00, 1, 8'h02, 8'h00, 8'h02);
    step(1, 0, 8'h12, full(8'h12),      0, 1, 0,  8'h00, 1, 8'h02, 8'h00, 8'h02);
    step(1, 0, 8'h12, full(8'h12),      0, 1, 1,  8'h00, 1, 8'h02, 8'h00, 8'h02);
    step(1, 0, 8'h12, full(8'h12),      0, 0, 0,  8'h10, 1, 8'h02, 8'h02, 8'h02);
    step(1, 0, 8'h12, full(8'h12),      0, 0, 0,  8'h02, 1, 8'h10, 8'h10, 8'h10);
    // E1 fails: no pop, not reselected this cycle, reselected next
    step(1, 0, 8'h02, full(8'h02),      0, 0, 1,  8'h00, 1, 8'h02, 8'h00, 8'h02);
    step(1, 0, 8'h02, full(8'h02),      0, 0, 0,  8'h02, 0, 8'h00, 8'h00, 8'h00);
    // E1 pops while E6 selected, then E6 pops
    step(1, 0, 8'h42, full(8'h42),      0, 0, 0,  8'h40, 1, 8'h02, 8'h02, 8'h02);
    step(1, 0, 8'h40, full(8'h40),      0, 0, 0,  8'h00, 1, 8'h40, 8'h40, 8'h40);
    step(1, 0, 8'h00, 24'h0,            0, 0, 0,  8'h00, 0, 8'h00, 8'h00, 8'h00);
    // E0 into pipe, flush during stall
    step(1, 0, 8'h01, full(8'h01),      0, 0, 0,  8'h01, 0, 8'h00, 8'h00, 8'h00);
    step(1, 1, 8'h81, full(8'h81),      0, 1, 0,  8'h00, 1, 8'h01, 8'h00, 8'h01);
    step(1, 0, 8'h81, full(8'h81),      0, 0, 0,  8'h01, 0, 8'h00, 8'h00, 8'h00);
    step(1, 0, 8'h81, full(8'h81),      0, 0, 0,  8'h80, 1, 8'h01, 8'h01, 8'h01);
    step(1, 0, 8'h00, 24'h0,            0, 0, 0,  8'h00, 1, 8'h80, 8'h80, 8'h80);
    // asynchronous reset mid-operation
    step(1, 0, 8'h08, full(8'h08),      0, 0, 0,  8'h08, 0, 8'h00, 8'h00, 8'h00);
    step(1, 0, 8'h08, full(8'h08),      0, 1, 0,  8'h00, 1, 8'h08, 8'h00, 8'h08);
    step(0, 0, 8'h08, full(8'h08),      0, 1, 0,  8'h08, 0, 8'h00, 8'h00, 8'h00);
    step(1, 0, 8'h00, 24'h0,            0, 0, 0,  8'h00, 0, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
